clk_div_multi: RTL

//   Multi-channel programmable clock divider; parametrised successor to the fixed single-output divider.

---
 rtl/clk_div_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with square-wave and tick outputs.
// One pending divisor-update slot; a new divisor lands on the target channel's period boundary.
module clk_div_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DIV_WIDTH   = 27,
    parameter int unsigned DEFAULT_DIV = 10000000,
    localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 inClock,
    input  logic                 clear,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 sync_all,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic [CHANNELS-1:0]  outClock,
    output logic [CHANNELS-1:0]  tick
);

    // Divisors below 2 cannot form a square wave, so they run as 2.
    localparam logic [DIV_WIDTH-1:0] RESET_DIV =
        (DEFAULT_DIV < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DEFAULT_DIV);

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
    endfunction

    logic [CHANNELS-1:0][DIV_WIDTH-1:0] cnt, cnt_nxt;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0] div, div_nxt;
    logic [CHANNELS-1:0]                out_nxt, tick_nxt;
    logic                               pend_valid, pend_valid_nxt;
    logic [CHAN_W-1:0]                  pend_chan, pend_chan_nxt;
    logic [DIV_WIDTH-1:0]               pend_div, pend_div_nxt;
    logic                               applied;
    logic                               wrap;
    logic [DIV_WIDTH-1:0]               half_len;
    logic [DIV_WIDTH-1:0]               cnt_step;

    // Next-state: per-channel counters, pending-slot apply and config capture.
    always_comb begin
        cnt_nxt        = cnt;
        div_nxt        = div;
        out_nxt        = outClock;
        tick_nxt       = tick;
        pend_valid_nxt = pend_valid;
        pend_chan_nxt  = pend_chan;
        pend_div_nxt   = pend_div;
        applied        = 1'b0;
        wrap           = 1'b0;
        half_len       = '0;
        cnt_step       = '0;

        for (int i = 0; i < int'(CHANNELS); i++) begin
            wrap     = (cnt[i] == div[i] - DIV_WIDTH'(1));
            half_len = (div[i] >> 1) + DIV_WIDTH'(div[i][0]);

            if (pend_valid && (pend_chan == CHAN_W'(i)) && (!enable[i] || sync_all || wrap)) begin
                div_nxt[i] = pend_div;
                applied    = 1'b1;
            end

            if (!enable[i] || sync_all) begin
                cnt_nxt[i]  = '0;
                out_nxt[i]  = 1'b0;
                tick_nxt[i] = 1'b0;
            end else begin
                cnt_step    = wrap ? '0 : cnt[i] + DIV_WIDTH'(1);
                cnt_nxt[i]  = cnt_step;
                out_nxt[i]  = (cnt_step >= half_len);
                tick_nxt[i] = wrap;
            end
        end

        if (applied) begin
            pend_valid_nxt = 1'b0;
        end

        // Out-of-range channel requests are accepted and dropped.
        if (cfg_valid && cfg_ready && (32'(cfg_chan) < CHANNELS)) begin
            pend_valid_nxt = 1'b1;
            pend_chan_nxt  = cfg_chan;
            pend_div_nxt   = clamp_div(cfg_div);
        end
    end

    always_ff @(posedge inClock or negedge clear) begin
        if (!clear) begin
            cnt        <= '0;
            div        <= {CHANNELS{RESET_DIV}};
            outClock   <= '0;
            tick       <= '0;
            pend_valid <= 1'b0;
            pend_chan  <= '0;
            pend_div   <= '0;
            cfg_ready  <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            div        <= div_nxt;
            outClock   <= out_nxt;
            tick       <= tick_nxt;
            pend_valid <= pend_valid_nxt;
            pend_chan  <= pend_chan_nxt;
            pend_div   <= pend_div_nxt;
            cfg_ready  <= !pend_valid_nxt;
        end
    end

endmodule
